// File: rtl/spike_pkg.sv
// Shared definitions for the synapse and neuron blocks: width defaults and the synapse state type.
package spike_pkg;

    localparam int SYN_W_DEF       = 10;
    localparam int RATE_W_DEF      = 9;
    localparam int DECAY_SHIFT_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } syn_state_t;

endpackage

// File: rtl/syn_prescaler.sv
// Programmable tick generator: one-cycle tick every period+1 enabled cycles, held at 0 when disabled.
module syn_prescaler #(
    parameter int W = 9
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Compare with >= so a period lowered below the running count ticks on the next cycle.
    always_comb begin
        tick  = enable && (cnt_q >= period);
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spike_synapse.sv
// Current-based synapse: each spike adds weight to a saturating current that decays
// proportionally on prescaled ticks; idles at zero with the prescaler parked.
module spike_synapse
    import spike_pkg::*;
#(
    parameter int SYN_W       = SYN_W_DEF,
    parameter int RATE_W      = RATE_W_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              spike_in,
    input  logic [RATE_W-1:0] weight,
    input  logic [RATE_W-1:0] decay_rate,
    output logic [SYN_W-1:0]  syn_o,
    output logic              active,
    output logic [15:0]       spike_cnt
);

    localparam int SUM_W = ((SYN_W > RATE_W) ? SYN_W : RATE_W) + 1;
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W - SYN_W){1'b0}}, {SYN_W{1'b1}}};

    syn_state_t        state_q, state_d;
    logic [SYN_W-1:0]  syn_q, syn_d;
    logic [SYN_W-1:0]  shifted, dec, syn_dec;
    logic [SUM_W-1:0]  sum;
    logic              active_q;
    logic [15:0]       cnt_q;
    logic              tick;

    syn_prescaler #(
        .W (RATE_W)
    ) u_prescaler (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (state_q == ACTIVE),
        .period (decay_rate),
        .tick   (tick)
    );

    // Decay first, then add the spike, then saturate.
    always_comb begin
        shifted = syn_q >> DECAY_SHIFT;
        dec     = shifted;
        if (shifted == '0 && syn_q != '0) begin
            dec = SYN_W'(1);
        end
        syn_dec = tick ? (syn_q - dec) : syn_q;
        sum     = SUM_W'(syn_dec) + (spike_in ? SUM_W'(weight) : '0);
        syn_d   = (sum > SAT) ? {SYN_W{1'b1}} : sum[SYN_W-1:0];
        state_d = (syn_d != '0) ? ACTIVE : IDLE;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            syn_q    <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            syn_q    <= syn_d;
            active_q <= (state_d == ACTIVE);
            if (spike_in) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign syn_o     = syn_q;
    assign active    = active_q;
    assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Bench for spike_synapse: directed scenarios plus randomized traffic against a behavioural model.
module tb_spike_synapse;

    localparam int SYN_W  = 10;
    localparam int RATE_W = 9;
    localparam int SYN_MAX = 1023;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              spike_in;
    logic [RATE_W-1:0] weight;
    logic [RATE_W-1:0] decay_rate;
    logic [SYN_W-1:0]  syn_o;
    logic              active;
    logic [15:0]       spike_cnt;

    int passed = 0;
    int total  = 0;

    // Behavioural model: current value, active cycles since last decay, spike count.
    int m_syn;
    int m_pre;
    int m_cnt;

    always #5 clk_in = ~clk_in;

    spike_synapse #(
        .SYN_W       (SYN_W),
        .RATE_W      (RATE_W),
        .DECAY_SHIFT (4)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .spike_in   (spike_in),
        .weight     (weight),
        .decay_rate (decay_rate),
        .syn_o      (syn_o),
        .active     (active),
        .spike_cnt  (spike_cnt)
    );

    task automatic model_step(input bit s, input int w, input int r);
        int v;
        int d;
        v = m_syn;
        if (v != 0) begin
            if (m_pre >= r) begin
                m_pre = 0;
                d = v / 16;
                if (d == 0) d = 1;
                v = v - d;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (s) begin
            m_cnt = (m_cnt + 1) % 65536;
            v = v + w;
            if (v > SYN_MAX) v = SYN_MAX;
        end
        if (v == 0) m_pre = 0;
        m_syn = v;
    endtask

    // Drive one clock cycle; outputs are valid for sampling on return (1 time unit after the edge).
    task automatic cycle(input bit s, input int w, input int r);
        spike_in   = s;
        weight     = RATE_W'(w);
        decay_rate = RATE_W'(r);
        @(posedge clk_in);
        model_step(s, w, r);
        #1;
        spike_in = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        spike_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        m_syn = 0;
        m_pre = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        spike_in   = 1'b0;
        weight     = '0;
        decay_rate = '0;
        #2;
        total++;
        if (syn_o !== 10'd0 || active !== 1'b0 || spike_cnt !== 16'd0)
            $display("FAIL reset_async: syn_o=%0d active=%0b cnt=%0d, want all 0", syn_o, active,
                     spike_cnt);
        else passed++;
        do_reset();
        cycle(0, 77, 0);
        total++;
        if (syn_o !== 10'd0 || active !== 1'b0 || spike_cnt !== 16'd0)
            $display("FAIL reset_release_quiet: syn_o=%0d active=%0b cnt=%0d, want all 0", syn_o,
                     active, spike_cnt);
        else passed++;
    endtask

    task automatic test_single_spike();
        do_reset();
        cycle(1, 100, 9);
        total++;
        if (syn_o !== 10'd100) $display("FAIL spike_syn: got %0d want 100", syn_o);
        else passed++;
        total++;
        if (active !== 1'b1) $display("FAIL spike_active: got %0b want 1", active);
        else passed++;
        total++;
        if (spike_cnt !== 16'd1) $display("FAIL spike_cnt: got %0d want 1", spike_cnt);
        else passed++;
    endtask

    // Continues from syn_o=100 left by test_single_spike.
    task automatic test_decay();
        repeat (9) cycle(0, 0, 9);
        total++;
        if (syn_o !== 10'd100) $display("FAIL decay_before_tick: got %0d want 100", syn_o);
        else passed++;
        cycle(0, 0, 9);
        total++;
        if (syn_o !== 10'd94) $display("FAIL decay_first_tick: got %0d want 94", syn_o);
        else passed++;
        repeat (10) cycle(0, 0, 9);
        total++;
        if (syn_o !== 10'd89) $display("FAIL decay_second_tick: got %0d want 89", syn_o);
        else passed++;
    endtask

    task automatic test_coincident();
        do_reset();
        cycle(1, 94, 9);
        repeat (9) cycle(0, 0, 9);
        cycle(1, 10, 9);
        total++;
        if (syn_o !== 10'd99) $display("FAIL tick_plus_spike: got %0d want 99", syn_o);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        cycle(1, 500, 511);
        cycle(1, 500, 511);
        total++;
        if (syn_o !== 10'd1000) $display("FAIL sat_build: got %0d want 1000", syn_o);
        else passed++;
        cycle(1, 100, 511);
        total++;
        if (syn_o !== 10'd1023) $display("FAIL sat_clip: got %0d want 1023", syn_o);
        else passed++;
    endtask

    task automatic test_decay_to_zero();
        int exp_v;
        do_reset();
        cycle(1, 5, 0);
        for (int i = 4; i >= 1; i--) begin
            cycle(0, 0, 0);
            exp_v = i;
            total++;
            if (int'(syn_o) != exp_v) $display("FAIL decay_step: got %0d want %0d", syn_o, exp_v);
            else passed++;
        end
        cycle(0, 0, 0);
        total++;
        if (syn_o !== 10'd0 || active !== 1'b0)
            $display("FAIL decay_zero: syn_o=%0d active=%0b want 0/0", syn_o, active);
        else passed++;
        cycle(0, 0, 3);
        cycle(1, 7, 3);
        repeat (3) cycle(0, 0, 3);
        total++;
        if (syn_o !== 10'd7) $display("FAIL prescaler_parked: got %0d want 7", syn_o);
        else passed++;
        cycle(0, 0, 3);
        total++;
        if (syn_o !== 10'd6) $display("FAIL prescaler_restart: got %0d want 6", syn_o);
        else passed++;
    endtask

    task automatic test_rate_decrease();
        do_reset();
        cycle(1, 200, 20);
        repeat (10) cycle(0, 0, 20);
        total++;
        if (syn_o !== 10'd200) $display("FAIL rate_hold: got %0d want 200", syn_o);
        else passed++;
        cycle(0, 0, 3);
        total++;
        if (syn_o !== 10'd188) $display("FAIL rate_drop_tick: got %0d want 188", syn_o);
        else passed++;
    endtask

    task automatic test_zero_weight();
        do_reset();
        cycle(1, 0, 5);
        total++;
        if (syn_o !== 10'd0 || active !== 1'b0 || spike_cnt !== 16'd1)
            $display("FAIL zero_weight: syn_o=%0d active=%0b cnt=%0d want 0/0/1", syn_o, active,
                     spike_cnt);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 250, 511);
        cycle(1, 250, 511);
        total++;
        if (syn_o !== 10'd500) $display("FAIL areset_build: got %0d want 500", syn_o);
        else passed++;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (syn_o !== 10'd0 || active !== 1'b0 || spike_cnt !== 16'd0)
            $display("FAIL areset_midcycle: syn_o=%0d active=%0b cnt=%0d want all 0", syn_o,
                     active, spike_cnt);
        else passed++;
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        m_syn = 0;
        m_pre = 0;
        m_cnt = 0;
        cycle(1, 30, 511);
        total++;
        if (syn_o !== 10'd30) $display("FAIL areset_restart: got %0d want 30", syn_o);
        else passed++;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        repeat (65535) cycle(1, 0, 0);
        total++;
        if (spike_cnt !== 16'hFFFF) $display("FAIL cnt_full: got %0h want ffff", spike_cnt);
        else passed++;
        cycle(1, 0, 0);
        total++;
        if (spike_cnt !== 16'h0000) $display("FAIL cnt_wrap: got %0h want 0", spike_cnt);
        else passed++;
    endtask

    task automatic test_random();
        int rate;
        int w;
        bit s;
        do_reset();
        rate = 4;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) rate = $urandom_range(0, 15);
            s = ($urandom_range(0, 7) == 0);
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40);
            cycle(s, w, rate);
            total++;
            if (int'(syn_o) != m_syn || active !== (m_syn != 0) || int'(spike_cnt) != m_cnt) begin
                $display("FAIL random[%0d]: syn_o=%0d active=%0b cnt=%0d want %0d/%0b/%0d", i,
                         syn_o, active, spike_cnt, m_syn, (m_syn != 0), m_cnt);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_decay();
        test_coincident();
        test_saturation();
        test_decay_to_zero();
        test_rate_decrease();
        test_zero_weight();
        test_async_reset();
        test_cnt_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
